nios_lcd_ctrl: RTL and testbench

- Avalon-MM slave command sequencer for an HD44780-class character LCD in 8-bit, write-only mode.
- Replaces software bit-banging of the separate EN/RS/data PIOs.
- Nios writes command/data bytes into a small FIFO. An internal FSM drives RS/data setup, the EN pulse, hold, and the controller execution delay for each entry.
- Sits on the Nios data master next to the other PIO slaves; zero-wait-state reads.

---
 rtl/nios_lcd_ctrl.sv | 213 +++++++++++++++++++++
 tb/tb_nios_lcd_ctrl.sv | 270 +++++++++++++++++++++++++++
 2 files changed

// File: rtl/nios_lcd_ctrl.sv
// nios_lcd_ctrl: Avalon-MM slave that sequences HD44780-class LCD writes
// (8-bit, write-only) out of a small command FIFO.
// Optional feature macro: NIOS_LCD_CTRL_IRQ_EN adds the irq port and the
// irq_en register at address 3; without it address 3 reads 0 and ignores writes.
module nios_lcd_ctrl #(
    parameter int unsigned FIFO_DEPTH = 4,
    parameter int unsigned SETUP_CYC  = 3,
    parameter int unsigned EN_CYC     = 25,
    parameter int unsigned HOLD_CYC   = 3,
    parameter int unsigned EXEC_CYC   = 2000,
    parameter int unsigned LONG_CYC   = 82000
) (
    input  logic        clk,
    input  logic        reset,
    input  logic [1:0]  address,
    input  logic        chipselect,
    input  logic        write_n,
    input  logic [31:0] writedata,
    output logic [31:0] readdata,
    output logic        lcd_en,
    output logic        lcd_rs,
    output logic        lcd_rw,
    output logic [7:0]  lcd_data
`ifdef NIOS_LCD_CTRL_IRQ_EN
    ,
    output logic        irq
`endif
);

    localparam int unsigned PW = (FIFO_DEPTH > 1) ? $clog2(FIFO_DEPTH) : 1;
    localparam int unsigned CW = $clog2(FIFO_DEPTH + 1);
    localparam int unsigned TW = 17;

    typedef enum logic [2:0] {
        S_IDLE,
        S_SETUP,
        S_PULSE,
        S_HOLD,
        S_WAIT
    } state_t;

    state_t         state_q, state_d;
    logic [TW-1:0]  tmr_q, tmr_d;

    logic [8:0]     mem_q [FIFO_DEPTH];
    logic [PW-1:0]  wr_ptr_q, rd_ptr_q;
    logic [CW-1:0]  count_q;
    logic           ovf_q;
    logic           lcd_rs_q;
    logic [7:0]     lcd_data_q;

    logic wr_en, push_req, push_ok, full, pop, busy, long_cmd;
    logic unused_wdata;

    assign wr_en    = chipselect & ~write_n;
    assign push_req = wr_en & ~address[1];
    assign full     = (count_q == CW'(FIFO_DEPTH));
    // Full is taken from the registered count, so a push in a pop cycle while full is dropped.
    assign push_ok  = push_req & ~full;
    assign pop      = (state_q == S_IDLE) && (count_q != '0);
    assign busy     = (state_q != S_IDLE) || (count_q != '0);
    // Clear display / return home need the long controller execution delay.
    assign long_cmd = ~lcd_rs_q && (lcd_data_q inside {8'h01, 8'h02, 8'h03});

    assign unused_wdata = ^writedata[31:8];

    // FIFO storage: written on an accepted push, no reset needed.
    always_ff @(posedge clk) begin
        if (push_ok) begin
            mem_q[wr_ptr_q] <= {address[0], writedata[7:0]};
        end
    end

    // FIFO pointers, occupancy and sticky overflow flag.
    always_ff @(posedge clk) begin
        if (reset) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            count_q  <= '0;
            ovf_q    <= 1'b0;
        end else begin
            if (push_ok) begin
                wr_ptr_q <= wr_ptr_q + PW'(1);
            end
            if (pop) begin
                rd_ptr_q <= rd_ptr_q + PW'(1);
            end
            case ({push_ok, pop})
                2'b10:   count_q <= count_q + CW'(1);
                2'b01:   count_q <= count_q - CW'(1);
                default: count_q <= count_q;
            endcase
            if (push_req && full) begin
                ovf_q <= 1'b1;
            end else if (wr_en && (address == 2'd2) && writedata[2]) begin
                ovf_q <= 1'b0;
            end
        end
    end

    // LCD RS/data pins load on pop and hold until the next pop.
    always_ff @(posedge clk) begin
        if (reset) begin
            lcd_rs_q   <= 1'b0;
            lcd_data_q <= '0;
        end else if (pop) begin
            {lcd_rs_q, lcd_data_q} <= mem_q[rd_ptr_q];
        end
    end

    // FSM state register and phase timer.
    always_ff @(posedge clk) begin
        if (reset) begin
            state_q <= S_IDLE;
            tmr_q   <= '0;
        end else begin
            state_q <= state_d;
            tmr_q   <= tmr_d;
        end
    end

    // FSM next state: each phase loads the timer with its length minus one.
    always_comb begin
        state_d = state_q;
        tmr_d   = tmr_q;
        case (state_q)
            S_IDLE: begin
                if (pop) begin
                    state_d = S_SETUP;
                    tmr_d   = TW'(SETUP_CYC - 1);
                end
            end
            S_SETUP: begin
                if (tmr_q == '0) begin
                    state_d = S_PULSE;
                    tmr_d   = TW'(EN_CYC - 1);
                end else begin
                    tmr_d = tmr_q - TW'(1);
                end
            end
            S_PULSE: begin
                if (tmr_q == '0) begin
                    state_d = S_HOLD;
                    tmr_d   = TW'(HOLD_CYC - 1);
                end else begin
                    tmr_d = tmr_q - TW'(1);
                end
            end
            S_HOLD: begin
                if (tmr_q == '0) begin
                    state_d = S_WAIT;
                    tmr_d   = long_cmd ? TW'(LONG_CYC - 1) : TW'(EXEC_CYC - 1);
                end else begin
                    tmr_d = tmr_q - TW'(1);
                end
            end
            S_WAIT: begin
                if (tmr_q == '0) begin
                    state_d = S_IDLE;
                end else begin
                    tmr_d = tmr_q - TW'(1);
                end
            end
            default: state_d = S_IDLE;
        endcase
    end

    // FSM outputs: EN follows the PULSE state, bus is write-only.
    always_comb begin
        lcd_en   = (state_q == S_PULSE);
        lcd_rw   = 1'b0;
        lcd_rs   = lcd_rs_q;
        lcd_data = lcd_data_q;
    end

`ifdef NIOS_LCD_CTRL_IRQ_EN
    logic irq_en_q;
    logic irq_q;

    // Interrupt enable register and registered idle-and-empty interrupt.
    always_ff @(posedge clk) begin
        if (reset) begin
            irq_en_q <= 1'b0;
            irq_q    <= 1'b0;
        end else begin
            if (wr_en && (address == 2'd3)) begin
                irq_en_q <= writedata[0];
            end
            irq_q <= irq_en_q && (state_q == S_IDLE) && (count_q == '0);
        end
    end

    assign irq = irq_q;
`endif

    // Zero-wait-state register read, chipselect ignored.
    always_comb begin
        readdata = '0;
        case (address)
            2'd2: begin
                readdata[7:4] = 4'(count_q);
                readdata[2]   = ovf_q;
                readdata[1]   = full;
                readdata[0]   = busy;
            end
`ifdef NIOS_LCD_CTRL_IRQ_EN
            2'd3: readdata[0] = irq_en_q;
`endif
            default: readdata = '0;
        endcase
    end

endmodule

// File: tb/tb_nios_lcd_ctrl.sv
// Self-checking bench for nios_lcd_ctrl: transaction-level timeline model,
// expected LCD writes queued at push time and checked by a pin monitor.
module tb_nios_lcd_ctrl;

    localparam int S = 2;
    localparam int E = 4;
    localparam int H = 2;
    localparam int X = 10;
    localparam int L = 50;
    localparam int D = 4;

    logic        clk = 1'b0;
    logic        reset = 1'b1;
    logic [1:0]  address = '0;
    logic        chipselect = 1'b0;
    logic        write_n = 1'b1;
    logic [31:0] writedata = '0;
    logic [31:0] readdata;
    logic        lcd_en, lcd_rs, lcd_rw;
    logic [7:0]  lcd_data;
`ifdef NIOS_LCD_CTRL_IRQ_EN
    logic        irq;
`endif

    nios_lcd_ctrl #(
        .FIFO_DEPTH(D), .SETUP_CYC(S), .EN_CYC(E),
        .HOLD_CYC(H), .EXEC_CYC(X), .LONG_CYC(L)
    ) dut (
        .clk(clk), .reset(reset), .address(address), .chipselect(chipselect),
        .write_n(write_n), .writedata(writedata), .readdata(readdata),
        .lcd_en(lcd_en), .lcd_rs(lcd_rs), .lcd_rw(lcd_rw), .lcd_data(lcd_data)
`ifdef NIOS_LCD_CTRL_IRQ_EN
        , .irq(irq)
`endif
    );

    always #5 clk = ~clk;

    int cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    int total = 0;
    int bad   = 0;

    typedef struct {
        int         push;
        int         pop;
        int         w;
        logic       rs;
        logic [7:0] d;
    } ent_t;

    ent_t acc[$];   // every accepted entry since last reset (timeline model)
    ent_t sb[$];    // LCD writes still expected on the pins
    int   free_at = 0;
    bit   ovf_m = 0;
    bit   irq_en_m = 0;
    int   rises = 0;

    function automatic int count_at(int n);
        int c = 0;
        foreach (acc[i]) if (acc[i].push <= n && acc[i].pop > n) c++;
        return c;
    endfunction

    function automatic bit busy_at(int n);
        if (count_at(n) != 0) return 1'b1;
        foreach (acc[i])
            if (acc[i].pop <= n && n <= acc[i].pop + S + E + H + acc[i].w - 1) return 1'b1;
        return 1'b0;
    endfunction

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %h expected %h (cycle %0d)", name, act, exp, cyc);
        end
    endtask

    task automatic wr(input logic [1:0] a, input logic [31:0] d);
        int   p;
        ent_t e;
        @(negedge clk);
        address = a; writedata = d; chipselect = 1'b1; write_n = 1'b0;
        p = cyc + 1;
        if (a <= 2'd1) begin
            if (count_at(p - 1) >= D) begin
                ovf_m = 1'b1;
            end else begin
                e.push = p;
                e.rs   = a[0];
                e.d    = d[7:0];
                e.w    = (!a[0] && (d[7:0] inside {8'h01, 8'h02, 8'h03})) ? L : X;
                e.pop  = (p + 1 > free_at) ? p + 1 : free_at;
                free_at = e.pop + S + E + H + e.w + 1;
                acc.push_back(e);
                sb.push_back(e);
            end
        end else if (a == 2'd2) begin
            if (d[2]) ovf_m = 1'b0;
        end else begin
            irq_en_m = d[0];
        end
        @(posedge clk);
        #1 chipselect = 1'b0; write_n = 1'b1;
    endtask

    task automatic chk_status(input string name);
        int         c;
        logic [31:0] exp;
        @(negedge clk);
        address = 2'd2;
        #1;
        c = count_at(cyc);
        exp = '0;
        exp[7:4] = 4'(c);
        exp[2]   = ovf_m;
        exp[1]   = (c == D);
        exp[0]   = busy_at(cyc);
        check(name, readdata, exp);
    endtask

    task automatic drain();
        int n = 0;
        while ((sb.size() != 0 || busy_at(cyc)) && n < 3000) begin
            @(negedge clk);
            n++;
        end
        if (n >= 3000) begin
            total++; bad++;
            $display("FAIL drain_timeout: got %0d pending expected 0", sb.size());
        end
    endtask

    // Pin monitor: pops the scoreboard on each EN rise and checks timing and pins.
    bit   prev_en = 0;
    bit   have_cur = 0;
    int   rise_c = 0;
    int   hold_chk = -1;
    ent_t cur;
    always @(negedge clk) begin
        if (reset) begin
            prev_en  = 1'b0;
            have_cur = 1'b0;
            hold_chk = -1;
        end else begin
            if (sb.size() != 0 && sb[0].pop == cyc)
                check("t0_pins", {23'b0, lcd_rs, lcd_data}, {23'b0, sb[0].rs, sb[0].d});
            if (lcd_en && !prev_en) begin
                rises++;
                if (sb.size() == 0) begin
                    total++; bad++;
                    $display("FAIL unexpected_en: got rise at %0d expected none", cyc);
                end else begin
                    cur = sb.pop_front();
                    have_cur = 1'b1;
                    rise_c = cyc;
                    check("en_rise_time", cyc, cur.pop + S);
                    check("rise_pins", {22'b0, lcd_rw, lcd_rs, lcd_data}, {22'b0, 1'b0, cur.rs, cur.d});
                end
            end
            if (!lcd_en && prev_en && have_cur) begin
                check("en_width", cyc - rise_c, E);
                hold_chk = cyc + H - 1;
            end
            if (have_cur && hold_chk == cyc) begin
                check("hold_pins", {23'b0, lcd_rs, lcd_data}, {23'b0, cur.rs, cur.d});
                have_cur = 1'b0;
                hold_chk = -1;
            end
            prev_en = lcd_en;
        end
    end

    initial begin
        #5_000_000;
        $display("FAIL global_timeout: got no finish expected finish");
        $fatal(1, "timeout");
    end

    initial begin
        int          r0, n;
        logic [31:0] d;
        logic [1:0]  a;
        repeat (3) @(posedge clk);
        @(negedge clk) reset = 1'b0;

        check("rst_pins", {21'b0, lcd_en, lcd_rw, lcd_rs, lcd_data}, 32'h0);
        chk_status("rst_status");

        // single data write, status followed cycle by cycle
        wr(2'd1, 32'h41);
        for (int i = 0; i < 20; i++) chk_status("busy_41");
        drain();

        // clear followed by data: long wait on the first
        wr(2'd0, 32'h01);
        wr(2'd1, 32'h42);
        drain();

        // overflow: one executing plus five back-to-back pushes
        wr(2'd1, 32'h50);
        for (int i = 0; i < 5; i++) wr(2'(i & 1), 32'h60 + i);
        chk_status("ovf_full");
        wr(2'd2, 32'h4);
        chk_status("ovf_clr");
        drain();
        chk_status("ovf_drained");

        // reset during the EN pulse
        wr(2'd1, 32'h55);
        n = 0;
        while (!lcd_en && n < 100) begin @(negedge clk); n++; end
        check("reach_pulse", {31'b0, lcd_en}, 32'h1);
        @(negedge clk);
        reset = 1'b1;
        sb.delete(); acc.delete();
        free_at = 0; ovf_m = 1'b0; irq_en_m = 1'b0;
        r0 = rises;
        @(posedge clk);
        #1 check("rst_mid_pins", {21'b0, lcd_en, lcd_rw, lcd_rs, lcd_data}, 32'h0);
        @(negedge clk) reset = 1'b0;
        chk_status("rst_mid_status");
        repeat (30) @(negedge clk);
        check("no_en_after_rst", rises, r0);

`ifdef NIOS_LCD_CTRL_IRQ_EN
        wr(2'd3, 32'h1);
        wr(2'd0, 32'h30);
        for (int i = 0; i < 30; i++) begin
            @(negedge clk);
            check("irq_30", {31'b0, irq}, {31'b0, irq_en_m && !busy_at(cyc - 1)});
        end
        wr(2'd1, 32'h31);
        for (int i = 0; i < 5; i++) begin
            @(negedge clk);
            check("irq_31", {31'b0, irq}, {31'b0, irq_en_m && !busy_at(cyc - 1)});
        end
        drain();
`else
        wr(2'd3, 32'h1);
        @(negedge clk);
        address = 2'd3;
        #1 check("addr3_rd", readdata, 32'h0);
`endif
        @(negedge clk);
        address = 2'd0;
        #1 check("addr0_rd", readdata, 32'h0);
        address = 2'd1;
        #1 check("addr1_rd", readdata, 32'h0);

        // randomized traffic against the timeline model
        for (int i = 0; i < 40; i++) begin
            repeat ($urandom_range(0, 25)) @(posedge clk);
            a = 2'($urandom_range(0, 1));
            if ($urandom_range(0, 3) == 0) d = $urandom_range(1, 3);
            else d = $urandom_range(0, 255);
            wr(a, d);
            if ($urandom_range(0, 7) == 0) wr(2'd2, 32'h4);
            chk_status("rnd_status");
        end
        drain();
        chk_status("final_status");

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
